// File: rtl/bcd_display_mux.sv
// ---------------------------------------------------------------------------
// bcd_display_mux
//   Scans a bank of common-anode 7-segment digits, one digit per scan slot.
//   It latches a packed BCD word and adds three features: leading-zero
//   blanking, per-digit blinking, and a flag for invalid BCD codes.
//
// Ports
//   Clock     : single clock, rising edge
//   Resetn    : asynchronous active-low reset
//   Entrada   : packed BCD word, digit i = Entrada[4i+3:4i], digit 0 = LSD
//   Carregar  : load strobe for Entrada
//   Piscar    : per-digit blink enable (sampled live)
//   Saida     : segments a..g (a = bit 6), active-low, registered
//   Anodo     : digit select, active-low one-hot, registered
//   Erro      : registered flag, high while any latched digit exceeds 9
// ---------------------------------------------------------------------------
module bcd_display_mux #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned SCAN_DIV      = 50000,
    parameter int unsigned BLINK_FRAMES  = 64,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic                      Clock,
    input  logic                      Resetn,
    input  logic [4*NUM_DIGITS-1:0]   Entrada,
    input  logic                      Carregar,
    input  logic [NUM_DIGITS-1:0]     Piscar,
    output logic [6:0]                Saida,
    output logic [NUM_DIGITS-1:0]     Anodo,
    output logic                      Erro
);

    localparam int unsigned PW = (SCAN_DIV > 1)     ? $clog2(SCAN_DIV)     : 1;
    localparam int unsigned IW = (NUM_DIGITS > 1)   ? $clog2(NUM_DIGITS)   : 1;
    localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    logic [4*NUM_DIGITS-1:0] shadow_q;
    logic [PW-1:0]           presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [FW-1:0]           frame_q, frame_d;
    logic                    phase_q, phase_d;
    logic [6:0]              saida_q, saida_d;
    logic [NUM_DIGITS-1:0]   anodo_q, anodo_d;
    logic                    erro_q, erro_d;

    logic                    presc_wrap, idx_wrap, frame_wrap;
    logic [3:0]              digit_cur;
    logic [6:0]              seg_dec;
    logic [NUM_DIGITS-1:0]   zero_from;   // bit i: digit i and all higher digits are 0
    logic                    zero_acc;
    logic                    lz_sel, blink_sel;

    // Scan timing: prescaler -> digit index -> frame counter -> blink phase
    always_comb begin
        presc_wrap = (presc_q == PW'(SCAN_DIV - 1));
        idx_wrap   = (idx_q   == IW'(NUM_DIGITS - 1));
        frame_wrap = (frame_q == FW'(BLINK_FRAMES - 1));

        presc_d = presc_wrap ? '0 : presc_q + 1'b1;
        idx_d   = idx_q;
        frame_d = frame_q;
        phase_d = phase_q;
        if (presc_wrap) begin
            idx_d = idx_wrap ? '0 : idx_q + 1'b1;
            if (idx_wrap) begin
                frame_d = frame_wrap ? '0 : frame_q + 1'b1;
                if (frame_wrap) begin
                    phase_d = ~phase_q;
                end
            end
        end
    end

    // Leading-zero mask built from the most significant digit downwards
    always_comb begin
        zero_from = '0;
        zero_acc  = 1'b1;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            zero_acc = zero_acc & (shadow_q[4*(NUM_DIGITS-1-k) +: 4] == 4'd0);
            zero_from[NUM_DIGITS-1-k] = zero_acc;
        end
    end

    // Select the current digit and its per-digit attributes
    always_comb begin
        digit_cur = '0;
        lz_sel    = 1'b0;
        blink_sel = 1'b0;
        anodo_d   = '1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == i[IW-1:0]) begin
                digit_cur  = shadow_q[4*i +: 4];
                lz_sel     = (i != 0) && zero_from[i];
                blink_sel  = Piscar[i];
                anodo_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        case (digit_cur)
            4'd0:    seg_dec = 7'b0000001;
            4'd1:    seg_dec = 7'b1001111;
            4'd2:    seg_dec = 7'b0010010;
            4'd3:    seg_dec = 7'b0000110;
            4'd4:    seg_dec = 7'b1001100;
            4'd5:    seg_dec = 7'b0100100;
            4'd6:    seg_dec = 7'b1100000;
            4'd7:    seg_dec = 7'b0001111;
            4'd8:    seg_dec = 7'b0000000;
            4'd9:    seg_dec = 7'b0001100;
            default: seg_dec = SEG_BLANK;
        endcase

        if (phase_q && blink_sel) begin
            saida_d = SEG_BLANK;
        end else if (BLANK_LEADING && lz_sel) begin
            saida_d = SEG_BLANK;
        end else begin
            saida_d = seg_dec;
        end
    end

    always_comb begin
        erro_d = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            erro_d = erro_d | (shadow_q[4*i +: 4] > 4'd9);
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            shadow_q <= '0;
            presc_q  <= '0;
            idx_q    <= '0;
            frame_q  <= '0;
            phase_q  <= 1'b0;
            saida_q  <= SEG_BLANK;
            anodo_q  <= '1;
            erro_q   <= 1'b0;
        end else begin
            if (Carregar) begin
                shadow_q <= Entrada;
            end
            presc_q <= presc_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            phase_q <= phase_d;
            saida_q <= saida_d;
            anodo_q <= anodo_d;
            erro_q  <= erro_d;
        end
    end

    assign Saida = saida_q;
    assign Anodo = anodo_q;
    assign Erro  = erro_q;

endmodule

// File: tb/tb_bcd_display_mux.sv
// ---------------------------------------------------------------------------
// tb_bcd_display_mux
//   Two instances share all inputs: one has leading-zero blanking enabled and
//   the other has it disabled. Expected outputs come from an arithmetic model
//   that uses the elapsed edge count and the latched word, and from a table of
//   hand-decoded words.
// ---------------------------------------------------------------------------
module tb_bcd_display_mux;

    localparam int unsigned N  = 4;
    localparam int unsigned SD = 4;
    localparam int unsigned BF = 2;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic [15:0] Entrada;
    logic        Carregar;
    logic [3:0]  Piscar;
    logic [6:0]  saida1, saida0;
    logic [3:0]  anodo1, anodo0;
    logic        erro1, erro0;

    always #5 Clock = ~Clock;

    bcd_display_mux #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLINK_FRAMES(BF), .BLANK_LEADING(1'b1)) dut_bl (
        .Clock(Clock), .Resetn(Resetn), .Entrada(Entrada), .Carregar(Carregar),
        .Piscar(Piscar), .Saida(saida1), .Anodo(anodo1), .Erro(erro1));

    bcd_display_mux #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLINK_FRAMES(BF), .BLANK_LEADING(1'b0)) dut_nb (
        .Clock(Clock), .Resetn(Resetn), .Entrada(Entrada), .Carregar(Carregar),
        .Piscar(Piscar), .Saida(saida0), .Anodo(anodo0), .Erro(erro0));

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state: edges elapsed since reset release, and the latched word
    int          cyc;
    logic [15:0] m_shadow;
    int          last_idx;

    logic [6:0] dec_tbl [0:15];

    typedef struct packed {
        logic [15:0]     word;
        logic [3:0][6:0] seg_bl;   // index = digit number
        logic [3:0][6:0] seg_nb;
        logic            err;
    } vec_t;

    vec_t vecs [8];

    localparam logic [6:0] BL = 7'b1111111;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cyc=%0d t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    function automatic logic [6:0] exp_seg(int idx, logic [15:0] sh, logic [3:0] pis,
                                           bit ph, bit blank_lead);
        logic [15:0] upper;
        logic [3:0]  d;
        upper = sh >> (4 * idx);
        d     = upper[3:0];
        if (ph && pis[idx]) return BL;
        if (blank_lead && idx > 0 && upper == 16'd0) return BL;
        return (d <= 4'd9) ? dec_tbl[d] : BL;
    endfunction

    function automatic bit exp_err(logic [15:0] sh);
        bit e = 1'b0;
        logic [15:0] t = sh;
        for (int k = 0; k < 4; k++) begin
            if (t[3:0] > 4'd9) e = 1'b1;
            t = t >> 4;
        end
        return e;
    endfunction

    // One clock edge: predict from pre-edge state, then compare #1 after it
    task automatic step();
        int   slot, idx, frame;
        bit   ph;
        logic [6:0] e1, e0;
        logic [3:0] ea;
        bit   ee;
        slot  = cyc / SD;
        idx   = slot % N;
        frame = slot / N;
        ph    = ((frame / BF) % 2) == 1;
        e1    = exp_seg(idx, m_shadow, Piscar, ph, 1'b1);
        e0    = exp_seg(idx, m_shadow, Piscar, ph, 1'b0);
        ea    = ~(4'b0001 << idx);
        ee    = exp_err(m_shadow);
        @(posedge Clock);
        if (Carregar) m_shadow = Entrada;
        cyc++;
        #1;
        check("saida_bl", {9'd0, saida1}, {9'd0, e1});
        check("saida_nb", {9'd0, saida0}, {9'd0, e0});
        check("anodo_bl", {12'd0, anodo1}, {12'd0, ea});
        check("anodo_nb", {12'd0, anodo0}, {12'd0, ea});
        check("erro_bl",  {15'd0, erro1}, {15'd0, ee});
        check("erro_nb",  {15'd0, erro0}, {15'd0, ee});
        last_idx = idx;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_saida_bl"}, {9'd0, saida1}, {9'd0, BL});
        check({tag, "_saida_nb"}, {9'd0, saida0}, {9'd0, BL});
        check({tag, "_anodo_bl"}, {12'd0, anodo1}, 16'h000F);
        check({tag, "_anodo_nb"}, {12'd0, anodo0}, 16'h000F);
        check({tag, "_erro_bl"},  {15'd0, erro1}, 16'd0);
        check({tag, "_erro_nb"},  {15'd0, erro0}, 16'd0);
    endtask

    task automatic do_reset();
        Carregar = 1'b0;
        Resetn   = 1'b0;
        @(posedge Clock);
        #1;
        check_reset_outputs("rst");
        Resetn   = 1'b1;
        cyc      = 0;
        m_shadow = '0;
    endtask

    initial begin
        logic [15:0] seg_w;
        bit found;

        dec_tbl[0] = 7'b0000001; dec_tbl[1] = 7'b1001111; dec_tbl[2] = 7'b0010010;
        dec_tbl[3] = 7'b0000110; dec_tbl[4] = 7'b1001100; dec_tbl[5] = 7'b0100100;
        dec_tbl[6] = 7'b1100000; dec_tbl[7] = 7'b0001111; dec_tbl[8] = 7'b0000000;
        dec_tbl[9] = 7'b0001100;
        for (int k = 10; k < 16; k++) dec_tbl[k] = BL;

        // Hand-decoded words; digit order in the braces is 3,2,1,0
        vecs[0] = '{16'h1234, {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100},
                              {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, 1'b0};
        vecs[1] = '{16'h0050, {BL, BL, 7'b0100100, 7'b0000001},
                              {7'b0000001, 7'b0000001, 7'b0100100, 7'b0000001}, 1'b0};
        vecs[2] = '{16'h00A3, {BL, BL, BL, 7'b0000110},
                              {7'b0000001, 7'b0000001, BL, 7'b0000110}, 1'b1};
        vecs[3] = '{16'h0003, {BL, BL, BL, 7'b0000110},
                              {7'b0000001, 7'b0000001, 7'b0000001, 7'b0000110}, 1'b0};
        vecs[4] = '{16'h0000, {BL, BL, BL, 7'b0000001},
                              {7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001}, 1'b0};
        vecs[5] = '{16'h9870, {7'b0001100, 7'b0000000, 7'b0001111, 7'b0000001},
                              {7'b0001100, 7'b0000000, 7'b0001111, 7'b0000001}, 1'b0};
        vecs[6] = '{16'h0605, {BL, 7'b1100000, 7'b0000001, 7'b0100100},
                              {7'b0000001, 7'b1100000, 7'b0000001, 7'b0100100}, 1'b0};
        vecs[7] = '{16'hF00B, {BL, 7'b0000001, 7'b0000001, BL},
                              {BL, 7'b0000001, 7'b0000001, BL}, 1'b1};

        cyc = 0; m_shadow = '0; last_idx = 0;
        Resetn = 1'b0; Carregar = 1'b0; Entrada = '0; Piscar = '0;

        // Reset state and first scan
        repeat (3) @(posedge Clock);
        #1;
        check_reset_outputs("init");
        Resetn = 1'b1;
        cyc = 0;
        step();
        check("first_saida", {9'd0, saida1}, 16'h0001);
        check("first_anodo", {12'd0, anodo1}, 16'h000E);
        repeat (4) step();
        check("slot1_anodo", {12'd0, anodo1}, 16'h000D);
        check("slot1_lzblank", {9'd0, saida1}, {9'd0, BL});
        repeat (12) step();
        check("frame_wrap_anodo", {12'd0, anodo1}, 16'h000E);

        // Table-driven loads: one full frame per word
        for (int v = 0; v < 8; v++) begin
            Entrada  = vecs[v].word;
            Carregar = 1'b1;
            step();
            Carregar = 1'b0;
            step();
            check("tbl_erro", {15'd0, erro1}, {15'd0, vecs[v].err});
            for (int s = 0; s < 16; s++) begin
                step();
                seg_w = {9'd0, vecs[v].seg_bl[last_idx]};
                check("tbl_seg_bl", {9'd0, saida1}, seg_w);
                seg_w = {9'd0, vecs[v].seg_nb[last_idx]};
                check("tbl_seg_nb", {9'd0, saida0}, seg_w);
            end
        end

        // Erro clears one edge after a valid word replaces an invalid one
        Entrada = 16'h00A3; Carregar = 1'b1; step();
        Carregar = 1'b0; step();
        check("erro_set", {15'd0, erro1}, 16'd1);
        Entrada = 16'h0003; Carregar = 1'b1; step();
        check("erro_hold", {15'd0, erro1}, 16'd1);
        Carregar = 1'b0; step();
        check("erro_clear", {15'd0, erro1}, 16'd0);

        // Blink on digit 0 across several half-periods
        do_reset();
        Piscar = 4'b0001; Entrada = 16'h0008; Carregar = 1'b1;
        step();
        Carregar = 1'b0;
        repeat (140) step();
        Piscar = 4'b0000;
        repeat (8) step();

        // Randomized traffic
        for (int r = 0; r < 500; r++) begin
            Carregar = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0)
                Entrada = 16'($urandom);
            else
                Entrada = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                           4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))} &
                          (16'hFFFF >> (4 * $urandom_range(0, 3)));
            if ($urandom_range(0, 15) == 0) Piscar = 4'($urandom);
            step();
        end
        Carregar = 1'b0;

        // Asynchronous reset in the middle of digit 2's slot
        Entrada = 16'h00A3; Carregar = 1'b1; step();
        Carregar = 1'b0;
        found = 1'b0;
        for (int w = 0; w < 40 && !found; w++) begin
            step();
            if (last_idx == 2 && erro1) found = 1'b1;
        end
        check("reach_digit2", {15'd0, found}, 16'd1);
        check("pre_reset_anodo", {12'd0, anodo1}, 16'h000B);
        #2;
        Resetn = 1'b0;
        #1;
        check_reset_outputs("async");
        @(posedge Clock);
        #1;
        check_reset_outputs("held");
        Resetn   = 1'b1;
        cyc      = 0;
        m_shadow = '0;
        step();
        check("restart_anodo", {12'd0, anodo1}, 16'h000E);
        check("restart_saida", {9'd0, saida1}, 16'h0001);
        repeat (20) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
